// File: rtl/param_queue_pkg.sv
// ----------------------------------------------------------------------------
// param_queue_pkg
// Shared constants and helper functions for the parametrised queue.
//   - DEFAULT_* : default parameter values for the queue and its interface
//   - count_width : width needed to hold an occupancy of 0..depth
//   - ptr_width   : width needed to address depth entries
//   - ptr_inc     : pointer increment with explicit wrap at depth-1
// ----------------------------------------------------------------------------
package param_queue_pkg;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_DEPTH    = 2;
    localparam int DEFAULT_AE_LEVEL = 1;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wrap is an explicit compare so non-power-of-two depths work.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == (depth - 32'd1)) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/param_queue_if.sv
// ----------------------------------------------------------------------------
// param_queue_if
// Producer/consumer handshake bundle for param_queue.
//   master : drives flush, enq, din, deq; observes status and head data
//   slave  : the queue side (receives requests, drives status and dout)
// Signals: flush, enq, din[WIDTH], deq, enq_ready, deq_valid, dout[WIDTH],
//          count[CW], almost_full, almost_empty
// ----------------------------------------------------------------------------
interface param_queue_if
    import param_queue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) ();
    localparam int CW = count_width(DEPTH);

    logic             flush;
    logic             enq;
    logic [WIDTH-1:0] din;
    logic             deq;
    logic             enq_ready;
    logic             deq_valid;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;

    modport master (
        output flush, enq, din, deq,
        input  enq_ready, deq_valid, dout, count, almost_full, almost_empty
    );

    modport slave (
        input  flush, enq, din, deq,
        output enq_ready, deq_valid, dout, count, almost_full, almost_empty
    );
endinterface

// File: rtl/param_queue_ram.sv
// ----------------------------------------------------------------------------
// param_queue_ram
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from storage)
// ----------------------------------------------------------------------------
module param_queue_ram #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/param_queue.sv
// ----------------------------------------------------------------------------
// param_queue
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// flags and synchronous flush.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (priority over flush)
//   q   : param_queue_if.slave (flush, enq/din, deq, enq_ready, deq_valid,
//         dout, count, almost_full, almost_empty)
// Optional feature macro: QUEUE_BYPASS_EN -- fall-through when empty
// (combinational enq->deq_valid and din->dout paths). Undefined by default.
// ----------------------------------------------------------------------------
module param_queue
    import param_queue_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = DEFAULT_AE_LEVEL
) (
    input logic          clk,
    input logic          rst,
    param_queue_if.slave q
);
    localparam int            CW      = count_width(DEPTH);
    localparam int            PW      = ptr_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   AF_U    = 32'(AF_LEVEL);
    localparam logic [31:0]   AE_U    = 32'(AE_LEVEL);

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             enq_ready_r;
    logic             deq_valid_r;
    logic             almost_full_r;
    logic             almost_empty_r;
    logic             wr_fire_s;
    logic             rd_fire_s;
    logic             pass_s;
    logic             wr_store_s;
    logic             rd_pop_s;
    logic             deq_valid_s;
    logic             ram_we_s;
    logic [WIDTH-1:0] rdata_s;

    // Handshake decode: which transfers fire and which touch storage
    always_comb begin
        wr_fire_s = q.enq && enq_ready_r;
`ifdef QUEUE_BYPASS_EN
        deq_valid_s = deq_valid_r || q.enq;
        // Empty queue with both sides active: the entry flows straight through.
        pass_s      = wr_fire_s && q.deq && !deq_valid_r;
`else
        deq_valid_s = deq_valid_r;
        pass_s      = 1'b0;
`endif
        rd_fire_s  = q.deq && deq_valid_s;
        wr_store_s = wr_fire_s && !pass_s;
        rd_pop_s   = rd_fire_s && !pass_s;
        ram_we_s   = wr_store_s && !rst && !q.flush;
    end

    // Next occupancy from the stored write/read events
    always_comb begin
        count_next_s = count_r;
        case ({wr_store_s, rd_pop_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, count and status-flag registers
    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            enq_ready_r    <= 1'b1;
            deq_valid_r    <= 1'b0;
            almost_full_r  <= (AF_U == 32'd0);
            almost_empty_r <= 1'b1;
        end else begin
            if (wr_store_s) begin
                wr_ptr_r <= PW'(ptr_inc(32'(wr_ptr_r), DEPTH));
            end
            if (rd_pop_s) begin
                rd_ptr_r <= PW'(ptr_inc(32'(rd_ptr_r), DEPTH));
            end
            // Flags are precomputed from the next count so they are
            // registers that line up with count_r.
            count_r        <= count_next_s;
            enq_ready_r    <= (count_next_s != DEPTH_C);
            deq_valid_r    <= (count_next_s != {CW{1'b0}});
            almost_full_r  <= (32'(count_next_s) >= AF_U);
            almost_empty_r <= (32'(count_next_s) <= AE_U);
        end
    end

    param_queue_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (q.din),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    assign q.enq_ready    = enq_ready_r;
    assign q.deq_valid    = deq_valid_s;
    assign q.count        = count_r;
    assign q.almost_full  = almost_full_r;
    assign q.almost_empty = almost_empty_r;
`ifdef QUEUE_BYPASS_EN
    assign q.dout = deq_valid_r ? rdata_s : q.din;
`else
    assign q.dout = rdata_s;
`endif
endmodule
